// File: rtl/lobster_pkg.sv
// Shared types for the lobster execution manager: ALU opcode enum and datapath width.
package lobster_pkg;

    localparam int XLEN = 128;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SHL  = 4'h5,
        ALU_SHR  = 4'h6,
        ALU_SAR  = 4'h7,
        ALU_MUL  = 4'h8,
        ALU_SLT  = 4'h9,
        ALU_SLTU = 4'hA,
        ALU_MIN  = 4'hB,
        ALU_MAX  = 4'hC,
        ALU_MOV  = 4'hD,
        ALU_ANDN = 4'hE,
        ALU_PASS = 4'hF
    } alu_op_t;

endpackage

// File: rtl/lobster_alu_shifter.sv
// Unified barrel shifter: left when dir=0, right when dir=1; arith selects sign fill on right shifts.
module lobster_alu_shifter #(
    parameter int WIDTH   = 128,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
    input  logic               arith,
    output logic [WIDTH-1:0]   y
);

    always_comb begin
        y = '0;
        if (!dir) begin
            y = a << shamt;
        end else if (arith) begin
            y = WIDTH'($signed(a) >>> shamt);
        end else begin
            y = a >> shamt;
        end
    end

endmodule

// File: rtl/lobster_alu.sv
// Combinational 128-bit integer ALU shared by the micro and mini executors.
// clk is carried only for interface uniformity; rst gates the result to zero.
module lobster_alu
    import lobster_pkg::*;
#(
    parameter int WIDTH   = XLEN,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c
);

    logic             unused_clk;
    logic [WIDTH-1:0] shift_y;
    logic [WIDTH-1:0] result;
    logic             lt_s;
    logic             lt_u;

    assign unused_clk = clk;

    assign lt_u = a < b;
    assign lt_s = $signed(a) < $signed(b);

    lobster_alu_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .a     (a),
        .shamt (b[SHAMT_W-1:0]),
        .dir   (op != ALU_SHL),
        .arith (op == ALU_SAR),
        .y     (shift_y)
    );

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SHL,
            ALU_SHR,
            ALU_SAR:  result = shift_y;
            ALU_MUL:  result = WIDTH'(a * b);
            ALU_SLT:  result = WIDTH'(lt_s);
            ALU_SLTU: result = WIDTH'(lt_u);
            ALU_MIN:  result = (lt_s || a == b) ? a : b;
            ALU_MAX:  result = (lt_s && a != b) ? b : a;
            ALU_MOV:  result = b;
            ALU_ANDN: result = a & ~b;
            ALU_PASS: result = a;
            // unknown opcode propagates as X instead of being masked
            default:  result = 'x;
        endcase
    end

    assign c = rst ? '0 : result;

endmodule

// File: tb/tb_lobster_alu.sv
// Directed and randomized self-checking bench for lobster_alu.
module tb_lobster_alu;
    import lobster_pkg::*;

    localparam int W = 128;

    logic         clk;
    logic         rst;
    alu_op_t      op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;

    int total = 0;
    int bad   = 0;

    lobster_alu dut (
        .clk (clk),
        .rst (rst),
        .op  (op),
        .a   (a),
        .b   (b),
        .c   (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic apply(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] exp);
        op = alu_op_t'(o);
        a  = x;
        b  = y;
        #1;
        check(tag, c, exp);
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [3:0] o, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
        logic [6:0]   s;
        logic         slt;
        logic [W-1:0] ones;
        logic [W-1:0] r;
        s    = y[6:0];
        ones = '1;
        slt  = (x[W-1] != y[W-1]) ? x[W-1] : (x < y);
        r    = '0;
        case (o)
            4'h0: r = x + y;
            4'h1: r = x + ~y + 1'b1;
            4'h2: r = x & y;
            4'h3: r = x | y;
            4'h4: r = x ^ y;
            4'h5: r = x << s;
            4'h6: r = x >> s;
            4'h7: r = (x >> s) | (x[W-1] ? ~(ones >> s) : '0);
            4'h8: r = W'(x * y);
            4'h9: r = W'(slt);
            4'hA: r = W'(x < y);
            4'hB: r = slt ? x : y;
            4'hC: r = (slt || x == y) ? ((x == y) ? x : y) : x;
            4'hD: r = y;
            4'hE: r = x & ~y;
            default: r = x;
        endcase
        return r;
    endfunction

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] msb_lsb;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [3:0]   ro;
        ones    = '1;
        msb_lsb = {1'b1, {(W-2){1'b0}}, 1'b1};

        rst = 1'b1;
        op  = ALU_ADD;
        a   = W'(5);
        b   = W'(7);
        @(negedge clk);
        check("reset_hold", c, '0);
        rst = 1'b0;
        #1;
        check("reset_release", c, W'(12));
        @(negedge clk);

        apply("add_wrap", 4'h0, ones, W'(1), '0);
        apply("sub_wrap", 4'h1, '0, W'(1), ones);
        apply("and",  4'h2, W'(16'hF0F0), W'(16'h0FF0), W'(16'h00F0));
        apply("or",   4'h3, W'(16'hF0F0), W'(16'h0FF0), W'(16'hFFF0));
        apply("xor",  4'h4, W'(16'hF0F0), W'(16'h0FF0), W'(16'hFF00));
        apply("andn", 4'hE, W'(16'hF0F0), W'(16'h0FF0), W'(16'hF000));
        apply("shl1", 4'h5, msb_lsb, W'(1), W'(2));
        apply("shr1", 4'h6, msb_lsb, W'(1), {2'b01, {(W-2){1'b0}}});
        apply("sar1", 4'h7, msb_lsb, W'(1), {2'b11, {(W-2){1'b0}}});
        apply("shl0_hi_ignored", 4'h5, msb_lsb, W'(12'h180), msb_lsb);
        apply("sar_max", 4'h7, msb_lsb, W'(127), ones);
        apply("shr_max", 4'h6, msb_lsb, W'(127), W'(1));
        apply("slt_neg", 4'h9, ones, W'(1), W'(1));
        apply("sltu_neg", 4'hA, ones, W'(1), '0);
        apply("min_neg", 4'hB, ones, W'(1), ones);
        apply("max_neg", 4'hC, ones, W'(1), W'(1));
        apply("slt_eq", 4'h9, W'(5), W'(5), '0);
        apply("sltu_eq", 4'hA, W'(5), W'(5), '0);
        apply("min_eq", 4'hB, W'(5), W'(5), W'(5));
        apply("max_eq", 4'hC, W'(5), W'(5), W'(5));
        apply("mul_wrap", 4'h8, W'(1) << 64, W'(1) << 64, '0);
        apply("mul", 4'h8, W'(3), W'(7), W'(21));
        apply("mov", 4'hD, W'(3), W'(7), W'(7));
        apply("pass", 4'hF, W'(3), W'(7), W'(3));

        rst = 1'b1;
        apply("reset_mid", 4'hD, W'(3), W'(7), '0);
        rst = 1'b0;

        for (int i = 0; i < 10000; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            if (i % 4 == 1) rb = W'($urandom_range(0, 300));
            if (i % 8 == 3) rb = ra;
            apply("random", ro, ra, rb, ref_alu(ro, ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
